// File: rtl/l1d_arb_pkg.sv
// Shared types and constants for the L1D request arbiter.
package l1d_arb_pkg;

  localparam int unsigned L1D_ADDR_W = 64;
  localparam int unsigned L1D_DATA_W = 64;
  localparam int unsigned L1D_TAG_W  = 10;

  localparam logic SRC_LOAD  = 1'b0;
  localparam logic SRC_STORE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [L1D_ADDR_W-1:0] addr;
    logic [L1D_DATA_W-1:0] value;
    logic [L1D_TAG_W-1:0]  tag;
    logic                  we;
  } arb_req_t;

endpackage

// File: rtl/l1d_arb_req_slot.sv
// One-entry request register toward the L1D: loads on accept, holds while
// the L1D stalls, empties on the downstream handshake.
module l1d_arb_req_slot
  import l1d_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  arb_req_t req_d,
  input  logic     out_ready,
  output logic     out_valid,
  output arb_req_t req_q,
  output logic     can_load_c
);

  // Free this cycle if empty or the current entry leaves on this edge.
  assign can_load_c = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      req_q     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      req_q     <= req_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/l1d_req_arbiter.sv
// Arbitrates the load (r0) and store (r1) paths onto one L1D port, routes
// responses back by tag MSB, and sequences flushes.
// Define L1D_ARB_FIXED_PRIO_EN to give r0 strict priority instead of round-robin.
module l1d_req_arbiter
  import l1d_arb_pkg::*;
#(
  parameter int unsigned TAG_WIDTH       = L1D_TAG_W,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 cs_N_in,

  input  logic                 r0_valid_in,
  output logic                 r0_ready_out,
  input  logic [63:0]          r0_addr_in,
  input  logic [63:0]          r0_value_in,
  input  logic [TAG_WIDTH-2:0] r0_tag_in,
  input  logic                 r0_we_in,
  output logic                 r0_resp_valid_out,
  input  logic                 r0_resp_ready_in,
  output logic [63:0]          r0_resp_value_out,
  output logic [TAG_WIDTH-2:0] r0_resp_tag_out,
  output logic                 r0_write_complete_out,

  input  logic                 r1_valid_in,
  output logic                 r1_ready_out,
  input  logic [63:0]          r1_addr_in,
  input  logic [63:0]          r1_value_in,
  input  logic [TAG_WIDTH-2:0] r1_tag_in,
  input  logic                 r1_we_in,
  output logic                 r1_resp_valid_out,
  input  logic                 r1_resp_ready_in,
  output logic [63:0]          r1_resp_value_out,
  output logic [TAG_WIDTH-2:0] r1_resp_tag_out,
  output logic                 r1_write_complete_out,

  output logic                 l1d_valid_out,
  input  logic                 l1d_ready_in,
  output logic [63:0]          l1d_addr_out,
  output logic [63:0]          l1d_value_out,
  output logic [TAG_WIDTH-1:0] l1d_tag_out,
  output logic                 l1d_we_out,
  output logic                 l1d_flush_out,
  input  logic                 l1d_valid_in,
  output logic                 l1d_ready_out,
  input  logic [63:0]          l1d_value_in,
  input  logic [TAG_WIDTH-1:0] l1d_tag_in,
  input  logic                 l1d_write_complete_in,
  input  logic                 flush_req_in,
  output logic                 flush_ack_out
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // The slot payload struct carries a fixed-width tag.
  if (TAG_WIDTH != L1D_TAG_W) begin : g_tag_w_check
    $error("l1d_req_arbiter: TAG_WIDTH must equal l1d_arb_pkg::L1D_TAG_W");
  end

  arb_state_t       state_q, state_d;
  logic             flush_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       req_valid, elig, grant, accept, dec;
  logic             grant_ok, can_load, resp_src, resp_hs, slot_busy_next;
  arb_req_t         req_d, slot_q;

  assign req_valid = {r1_valid_in, r0_valid_in};

  // A flush request blocks grants in the very cycle it is seen.
  assign grant_ok = (state_q == IDLE) && !cs_N_in && !flush_req_in;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] && grant_ok && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

`ifdef L1D_ARB_FIXED_PRIO_EN
  assign grant[0] = elig[0];
  assign grant[1] = elig[1] && !elig[0];
`else
  logic last_grant_q;

  assign grant[0] = elig[0] && (!elig[1] || last_grant_q);
  assign grant[1] = elig[1] && (!elig[0] || !last_grant_q);

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in)     last_grant_q <= 1'b1;
    else if (|accept)  last_grant_q <= accept[1];
  end
`endif

  assign accept       = grant & {2{can_load}};
  assign r0_ready_out = accept[0];
  assign r1_ready_out = accept[1];

  always_comb begin
    req_d = '0;
    if (accept[1]) begin
      req_d.addr  = r1_addr_in;
      req_d.value = r1_value_in;
      req_d.tag   = L1D_TAG_W'({SRC_STORE, r1_tag_in});
      req_d.we    = r1_we_in;
    end else begin
      req_d.addr  = r0_addr_in;
      req_d.value = r0_value_in;
      req_d.tag   = L1D_TAG_W'({SRC_LOAD, r0_tag_in});
      req_d.we    = r0_we_in;
    end
  end

  l1d_arb_req_slot u_slot (
    .clk        (clk_in),
    .rst_n      (rst_N_in),
    .load       (|accept),
    .req_d      (req_d),
    .out_ready  (l1d_ready_in),
    .out_valid  (l1d_valid_out),
    .req_q      (slot_q),
    .can_load_c (can_load)
  );

  assign l1d_addr_out  = slot_q.addr;
  assign l1d_value_out = slot_q.value;
  assign l1d_tag_out   = TAG_WIDTH'(slot_q.tag);
  assign l1d_we_out    = slot_q.we;

  // Response routing is purely combinational and ignores cs/flush state.
  assign resp_src      = l1d_tag_in[TAG_WIDTH-1];
  assign l1d_ready_out = resp_src ? r1_resp_ready_in : r0_resp_ready_in;
  assign resp_hs       = l1d_valid_in && l1d_ready_out;
  assign dec           = {resp_hs && resp_src, resp_hs && !resp_src};

  assign r0_resp_valid_out     = l1d_valid_in && !resp_src;
  assign r1_resp_valid_out     = l1d_valid_in && resp_src;
  assign r0_resp_value_out     = l1d_value_in;
  assign r1_resp_value_out     = l1d_value_in;
  assign r0_resp_tag_out       = l1d_tag_in[TAG_WIDTH-2:0];
  assign r1_resp_tag_out       = l1d_tag_in[TAG_WIDTH-2:0];
  assign r0_write_complete_out = l1d_write_complete_in;
  assign r1_write_complete_out = l1d_write_complete_in;

  // Outstanding counters: simultaneous inc/dec cancels, dec saturates at 0.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!accept[i] && dec[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // No grants happen in DRAIN, so the slot can only empty, never refill.
  assign slot_busy_next = l1d_valid_out && !l1d_ready_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req_in) state_d = DRAIN;
      DRAIN:   if (!slot_busy_next && (cnt_d[0] == '0) && (cnt_d[1] == '0)) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= (state_d == FLUSH);
    end
  end

  assign l1d_flush_out = flush_q;
  assign flush_ack_out = flush_q;

endmodule
